// File: rtl/mul_share_ctrl_if.sv
// Bus bundle for mul_share_ctrl: request ports, shared-multiplier operands/product,
// response channel, flush and busy. slave = controller side, master = environment side.
interface mul_share_ctrl_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0]       req_op;
  logic             flush;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_product;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [63:0]      rsp_result;
  logic             rsp_overflow;
  logic             rsp_trap;
  logic             busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, flush, mul_product, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_trap, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, flush, mul_product, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_trap, busy
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing of one external multicycle 32x32 signed multiplier between two
// requesters. Optional MUL_SHARE_TRAP_EN: overflow raises rsp_trap and substitutes the result.
module mul_share_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input logic              clk,
  input logic              rst_n,
  mul_share_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        last_q;
  logic        op_q;
  logic        id_q;
  logic [31:0] mul_a_q, mul_b_q;
  logic [63:0] result_q;
  logic        overflow_q;
  logic        trap_q;

  logic        gnt_en;
  logic        gnt_id;
  logic        capture;
  logic [63:0] result_d;
  logic        overflow_d;
  logic        trap_d;

  // Arbitration: alternate on contention, otherwise serve whoever is asking.
  always_comb begin
    gnt_en = (state_q == StIdle) && (|bus.req_valid) && !bus.flush;
    case (bus.req_valid)
      2'b11:   gnt_id = ~last_q;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

  assign capture = (state_q == StExec) && !bus.flush && (cnt_q == 4'd0);

  // Result post-processing from the product currently on the multiplier output.
  always_comb begin
    overflow_d = op_q && !((&bus.mul_product[63:31]) || !(|bus.mul_product[63:31]));
    result_d   = op_q ? {{32{bus.mul_product[31]}}, bus.mul_product[31:0]} : bus.mul_product;
`ifdef MUL_SHARE_TRAP_EN
    trap_d     = overflow_d;
    if (trap_d) result_d = 64'hBAD0_BAD0_BAD0_BAD0;
`else
    trap_d     = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides both capture and the response handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (gnt_en) state_d = StExec;
      StExec: begin
        if (bus.flush)   state_d = StIdle;
        else if (capture) state_d = StResp;
      end
      StResp: begin
        if (bus.flush || bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.req_ready = 2'b00;
    if (gnt_en) bus.req_ready[gnt_id] = 1'b1;
    bus.rsp_valid    = (state_q == StResp);
    bus.busy         = (state_q != StIdle);
    bus.mul_a        = mul_a_q;
    bus.mul_b        = mul_b_q;
    bus.rsp_id       = id_q;
    bus.rsp_result   = result_q;
    bus.rsp_overflow = overflow_q;
    bus.rsp_trap     = trap_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
      result_q   <= 64'd0;
      overflow_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      if (gnt_en) begin
        mul_a_q <= bus.req_a[gnt_id];
        mul_b_q <= bus.req_b[gnt_id];
        op_q    <= bus.req_op[gnt_id];
        id_q    <= gnt_id;
        last_q  <= gnt_id;
        cnt_q   <= 4'(LATENCY - 1);
      end else if ((state_q == StExec) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        result_q   <= result_d;
        overflow_q <= overflow_d;
        trap_q     <= trap_d;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed self-checking bench for mul_share_ctrl; the shared multiplier is modelled
// here as a combinational signed product of mul_a/mul_b.
module tb_mul_share_ctrl;
  localparam int unsigned LAT = 2;
`ifdef MUL_SHARE_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passes = 0;

  mul_share_ctrl_if bus ();

  mul_share_ctrl #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mul_product = 64'($signed(bus.mul_a)) * 64'($signed(bus.mul_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.rsp_valid), 64'd1);
  endtask

  // Present a request in an idle cycle, check it is accepted, then drop it.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    bus.req_valid[i] = 1'b1;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_op[i]    = op;
    #1;
    chk("accept", 64'(bus.req_ready), (i == 1) ? 64'd2 : 64'd1);
    tick();
    bus.req_valid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int r;
    int last_t;
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 2'b00;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst_mul_b", 64'(bus.mul_b), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_result", bus.rsp_result, 64'd0);
    chk("rst_overflow", 64'(bus.rsp_overflow), 64'd0);
    chk("rst_trap", 64'(bus.rsp_trap), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // Signed full product, exact latency
    issue(0, 32'd3, 32'hFFFF_FFFC, 1'b0);
    chk("t1_mul_a", 64'(bus.mul_a), 64'd3);
    chk("t1_mul_b", 64'(bus.mul_b), 64'hFFFF_FFFC);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_no_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t1_not_yet", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_id", 64'(bus.rsp_id), 64'd0);
    chk("t1_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("t1_ovf", 64'(bus.rsp_overflow), 64'd0);
    chk("t1_trap", 64'(bus.rsp_trap), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_idle", 64'(bus.busy), 64'd0);
    chk("t1_rsp_drop", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b0;

    // Low-word overflow from requester 1, then backpressure with requester 0 waiting
    issue(1, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_rsp("t2_timeout");
    chk("t2_id", 64'(bus.rsp_id), 64'd1);
    chk("t2_result", bus.rsp_result, TrapEn ? 64'hBAD0_BAD0_BAD0_BAD0 : 64'd0);
    chk("t2_ovf", 64'(bus.rsp_overflow), 64'd1);
    chk("t2_trap", 64'(bus.rsp_trap), 64'(TrapEn));
    bus.req_valid[0] = 1'b1;
    bus.req_a[0]     = 32'hFFFF_FFFE;
    bus.req_b[0]     = 32'd3;
    bus.req_op[0]    = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_id", 64'(bus.rsp_id), 64'd1);
      chk("bp_result", bus.rsp_result, TrapEn ? 64'hBAD0_BAD0_BAD0_BAD0 : 64'd0);
      chk("bp_ovf", 64'(bus.rsp_overflow), 64'd1);
      chk("bp_no_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_idle", 64'(bus.busy), 64'd0);
    chk("bp_next_grant", 64'(bus.req_ready), 64'd1);
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid[0] = 1'b0;
    wait_rsp("t3_timeout");
    chk("t3_id", 64'(bus.rsp_id), 64'd0);
    chk("t3_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("t3_ovf", 64'(bus.rsp_overflow), 64'd0);
    chk("t3_trap", 64'(bus.rsp_trap), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Flush in IDLE blocks the grant; flush on the capture cycle drops the op
    bus.flush        = 1'b1;
    bus.req_valid[0] = 1'b1;
    bus.req_a[0]     = 32'd100;
    bus.req_b[0]     = 32'd200;
    bus.req_op[0]    = 1'b0;
    #1;
    chk("fl_idle_block", 64'(bus.req_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fl_accept", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("fl_idle", 64'(bus.busy), 64'd0);
    tick();
    chk("fl_still_no_rsp", 64'(bus.rsp_valid), 64'd0);
    issue(1, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 1'b0);
    wait_rsp("fl_next_timeout");
    chk("fl_next_id", 64'(bus.rsp_id), 64'd1);
    chk("fl_next_result", bus.rsp_result, 64'd56);
    bus.rsp_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    chk("fl_hs_idle", 64'(bus.busy), 64'd0);
    chk("fl_hs_drop", 64'(bus.rsp_valid), 64'd0);
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;

    // Asynchronous reset mid-EXEC, off the clock edge
    issue(0, 32'd9, 32'd9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_mul_a", 64'(bus.mul_a), 64'd0);
    chk("ar_result", bus.rsp_result, 64'd0);
    chk("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("ar_rsp_id", 64'(bus.rsp_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness with both requesters held valid; first grant goes to requester 0
    bus.req_valid = 2'b11;
    bus.req_a[0]  = 32'd5;
    bus.req_b[0]  = 32'd7;
    bus.req_op[0] = 1'b0;
    bus.req_a[1]  = 32'hFFFF_FFFA;
    bus.req_b[1]  = 32'd9;
    bus.req_op[1] = 1'b0;
    bus.rsp_ready = 1'b1;
    g = 0;
    r = 0;
    last_t = 0;
    for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
      #1;
      chk("fair_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      if (bus.req_ready != 2'b00) begin
        chk("fair_grant", 64'(bus.req_ready), (g % 2 == 1) ? 64'd2 : 64'd1);
        if (g > 0) chk("fair_interval", 64'(cyc - last_t), 64'(LAT + 2));
        last_t = cyc;
        g++;
      end
      if (bus.rsp_valid) begin
        chk("fair_id", 64'(bus.rsp_id), 64'(r % 2));
        chk("fair_result", bus.rsp_result,
            (r % 2 == 1) ? 64'hFFFF_FFFF_FFFF_FFCA : 64'd35);
        r++;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    chk("fair_done", 64'(r), 64'd4);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Controller that shares one external combinational signed 32x32 multiplier between two requesters (integer-issue port 0, port 1). It arbitrates round-robin, holds operands stable on the multiplier inputs for a fixed multicycle window, and samples the 64-bit product. It then post-processes the result (full or low-word with overflow check, optional trap substitution) and returns it with the requester id on a single valid/ready response channel. It sits between the issue logic and the shared multiplier instance; one operation is in flight at a time.

## Interface
- LATENCY, default 2: cycles the multiplier inputs are held before the product is sampled; legal range 1..15.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit set.
- req_a  in  2x32  operand A per requester, signed.
- req_b  in  2x32  operand B per requester, signed.
- req_op  in  2x1  0 = full 64-bit product, 1 = low word, sign-extended, overflow-checked.
- flush  in  1  synchronous abort of the in-flight operation.
- mul_a  out  32  operand A to the shared multiplier.
- mul_b  out  32  operand B to the shared multiplier.
- mul_product  in  64  signed product from the shared multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  64  result.
- rsp_overflow  out  1  low-word op did not fit in 32 signed bits.
- rsp_trap  out  1  trap raised (see Configuration).
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid and !flush, grant one requester and assert its req_ready combinationally.
  - On the grant cycle, latch the granted requester's operands into mul_a/mul_b, latch op and id, load cnt = LATENCY-1, and go to EXEC.
- Arbitration:
  - If both requesters are valid, grant the one not granted last.
  - If only one is valid, grant it.
  - The last-grant pointer updates only on a grant. After reset it favours requester 0.
- EXEC:
  - mul_a/mul_b are held constant.
  - If cnt != 0, decrement.
  - If cnt == 0, sample mul_product, compute the response fields, and go to RESP.
- RESP:
  - rsp_valid = 1. All rsp_* fields are held stable until the handshake.
  - On rsp_ready, go to IDLE. No grant happens in that same cycle.
- Arithmetic:
  - op=0: rsp_result = mul_product; rsp_overflow = 0.
  - op=1: rsp_result = sign-extend(mul_product[31:0]); rsp_overflow = (mul_product[63:31] not all equal).
- flush:
  - In EXEC or RESP, return to IDLE next cycle. The response is dropped and rsp_valid deasserts next cycle.
  - In IDLE, no grant is made.
  - flush has priority over rsp_ready and over the cnt==0 capture.
- mul_a/mul_b keep their last values in IDLE and are not cleared.
- Reset mid-operation: immediate return to reset values; the in-flight operation is lost.

## Timing
- Reset values: state IDLE, req_ready 0, mul_a 0, mul_b 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_overflow 0, rsp_trap 0, busy 0, last-grant pointer = 1 (so requester 0 is favoured first).
- Accept handshake in cycle T:
  - mul_a/mul_b valid from T+1.
  - Product sampled at the end of cycle T+LATENCY.
  - rsp_valid first high in T+LATENCY+1.
- Minimum accept-to-accept interval: LATENCY+2 cycles, with rsp_ready tied high.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and operands until accepted.
- rsp_valid stays high until rsp_ready; no field changes while stalled.

## Configuration
- MUL_SHARE_TRAP_EN defined:
  - rsp_trap = rsp_overflow.
  - When trap is set, rsp_result = 64'hBAD0_BAD0_BAD0_BAD0.
- Not defined:
  - rsp_trap is constant 0.
  - rsp_result is never substituted.
  - rsp_overflow is still reported.

## Test plan
- Signed full product: LATENCY=2; req0 a=3, b=-4, op=0 at T -> rsp_valid at T+3, rsp_id=0, result 0xFFFF_FFFF_FFFF_FFF4, overflow 0.
- Low-word overflow: a=0x0001_0000, b=0x0001_0000, op=1:
  - Without the macro -> result 0, overflow 1, trap 0.
  - With MUL_SHARE_TRAP_EN -> result 0xBAD0_BAD0_BAD0_BAD0, trap 1.
  - a=-2, b=3, op=1 -> result 0xFFFF_FFFF_FFFF_FFFA, overflow 0.
- Fairness: both req_valid held high for 4 operations -> grants 0,1,0,1; each req_ready is a single-cycle pulse; never two bits set.
- Backpressure: rsp_ready low 5 cycles in RESP -> all rsp_* stable; req_ready stays 0; on rsp_ready, IDLE next cycle and the next grant one cycle after that.
- Flush: flush in EXEC (LATENCY=4, cycle T+2) -> no rsp_valid for that op; the next request is accepted normally with the correct result. Flush with rsp_valid and rsp_ready both high -> response dropped, IDLE.
- Async reset: assert rst_n=0 mid-EXEC, off the clock edge -> all outputs immediately at reset values; after release, the first simultaneous request is granted to requester 0.
